// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration bank: command/response encodings,
// FSM states, and the default map for the standard four-slot configuration.
package cfg_pkg;

  localparam int CFG_NUM = 4;
  localparam int CFG_DW  = 8;

  // Slot roles in the standard map.
  localparam int SLOT_MAX_PER_SIZE = 0;
  localparam int SLOT_ELEM_MIN     = 1;
  localparam int SLOT_ELEM_MAX     = 2;
  localparam int SLOT_COUNTDOWN    = 3;

  // Packed per-slot values, slot 0 in the LSBs.
  localparam logic [CFG_NUM*CFG_DW-1:0] CFG_DEFAULTS    = {8'd10, 8'd9,  8'd0,  8'd2};
  localparam logic [CFG_NUM*CFG_DW-1:0] CFG_LO_BOUNDS   = {8'd1,  8'h80, 8'h80, 8'd1};
  localparam logic [CFG_NUM*CFG_DW-1:0] CFG_HI_BOUNDS   = {8'd99, 8'h7F, 8'h7F, 8'd10};
  localparam logic [CFG_NUM-1:0]        CFG_SIGNED_MASK = 4'b0110;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'd0,
    OP_COMMIT  = 2'd1,
    OP_ABORT   = 2'd2,
    OP_RESTORE = 2'd3
  } cfg_op_e;

  typedef enum logic [2:0] {
    RSP_OK      = 3'd0,
    RSP_BAD_IDX = 3'd1,
    RSP_RANGE   = 3'd2,
    RSP_EMPTY   = 3'd3,
    RSP_ORDER   = 3'd4
  } cfg_rsp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_APPLY = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/cfg_range_check.sv
// Inclusive bounds check of one slot value, signed or unsigned per slot.
module cfg_range_check #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] value,
  input  logic [DW-1:0] lo,
  input  logic [DW-1:0] hi,
  input  logic          signed_en,
  output logic          in_range
);

  // lo <= value <= hi, interpreting all three as two's complement when signed_en
  always_comb begin
    if (signed_en) begin
      in_range = ($signed(value) >= $signed(lo)) && ($signed(value) <= $signed(hi));
    end else begin
      in_range = (value >= lo) && (value <= hi);
    end
  end

endmodule

// File: rtl/config_bank.sv
// Transactional configuration bank: writes go to a shadow copy, COMMIT moves
// dirty slots to the active copy after a min<=max pair check. Every command
// takes three cycles (IDLE -> CHECK -> APPLY) and ends with one response pulse.
module config_bank
  import cfg_pkg::*;
#(
  parameter int                      NUM_CFG     = CFG_NUM,
  parameter int                      DW          = CFG_DW,
  parameter int                      IDX_W       = 2,
  parameter logic [NUM_CFG*DW-1:0]   DEFAULTS    = CFG_DEFAULTS,
  parameter logic [NUM_CFG*DW-1:0]   LO_BOUNDS   = CFG_LO_BOUNDS,
  parameter logic [NUM_CFG*DW-1:0]   HI_BOUNDS   = CFG_HI_BOUNDS,
  parameter logic [NUM_CFG-1:0]      SIGNED_MASK = CFG_SIGNED_MASK,
  parameter int                      PAIR_LO     = SLOT_ELEM_MIN,
  parameter int                      PAIR_HI     = SLOT_ELEM_MAX
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [IDX_W-1:0]        cmd_idx,
  input  logic [DW-1:0]           cmd_data,
  output logic                    rsp_valid,
  output logic [2:0]              rsp_code,
  input  logic                    rd_shadow,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DW-1:0]           rd_data,
  output logic [NUM_CFG*DW-1:0]   cfg_flat,
  output logic [NUM_CFG-1:0]      cfg_update,
  output logic                    pending
);

  localparam int SLOT_W  = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam bit PAIR_EN = (PAIR_LO != PAIR_HI);

  cfg_state_e            state_q, state_d;
  cfg_op_e               op_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DW-1:0]         data_q;
  cfg_rsp_e              code_q, check_code, rsp_code_q;
  logic [NUM_CFG*DW-1:0] shadow_q, active_q;
  logic [NUM_CFG-1:0]    dirty_q, cfg_update_q;
  logic                  rsp_valid_q;
  logic [DW-1:0]         rd_data_q, rd_next;

  logic                  accept, idx_ok, rd_ok, in_range, pair_ok;
  logic [SLOT_W-1:0]     wr_slot, rd_slot;
  logic [DW-1:0]         lo_sel, hi_sel, pair_a, pair_b;
  logic                  sgn_sel;

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a command walks IDLE -> CHECK -> APPLY -> IDLE
  always_comb begin
    // NOTE: default first, so no path leaves state_d unassigned and no latch appears.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cmd_valid) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_APPLY;
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the bank only takes a new command while idle
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
  end

  assign accept  = cmd_valid && cmd_ready;
  assign idx_ok  = (int'(idx_q) < NUM_CFG);
  assign wr_slot = idx_q[SLOT_W-1:0];
  assign rd_ok   = (int'(rd_idx) < NUM_CFG);
  assign rd_slot = rd_idx[SLOT_W-1:0];
  assign pair_a  = shadow_q[PAIR_LO*DW +: DW];
  assign pair_b  = shadow_q[PAIR_HI*DW +: DW];

  // Bounds of the addressed slot; zeros for a bad index, whose result is unused
  always_comb begin
    lo_sel  = '0;
    hi_sel  = '0;
    sgn_sel = 1'b0;
    if (idx_ok) begin
      lo_sel  = LO_BOUNDS[int'(wr_slot)*DW +: DW];
      hi_sel  = HI_BOUNDS[int'(wr_slot)*DW +: DW];
      sgn_sel = SIGNED_MASK[wr_slot];
    end
  end

  cfg_range_check #(.DW(DW)) u_range (
    .value     (data_q),
    .lo        (lo_sel),
    .hi        (hi_sel),
    .signed_en (sgn_sel),
    .in_range  (in_range)
  );

  // Pair check on the shadow copy: clean slots there equal their active value
  always_comb begin
    pair_ok = 1'b1;
    if (PAIR_EN) begin
      if (SIGNED_MASK[PAIR_LO]) pair_ok = ($signed(pair_a) <= $signed(pair_b));
      else                      pair_ok = (pair_a <= pair_b);
    end
  end

  // Outcome of the latched command, registered on the CHECK edge
  always_comb begin
    check_code = RSP_OK;
    unique case (op_q)
      OP_WRITE: begin
        if (!idx_ok)        check_code = RSP_BAD_IDX;
        else if (!in_range) check_code = RSP_RANGE;
      end
      OP_COMMIT: begin
        if (dirty_q == '0)  check_code = RSP_EMPTY;
        else if (!pair_ok)  check_code = RSP_ORDER;
      end
      default: check_code = RSP_OK;
    endcase
  end

  // Read mux: out-of-range indices read as zero
  always_comb begin
    rd_next = '0;
    if (rd_ok) begin
      rd_next = rd_shadow ? shadow_q[int'(rd_slot)*DW +: DW]
                          : active_q[int'(rd_slot)*DW +: DW];
    end
  end

  // Command capture, check result, APPLY-edge state update and response pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the slot arrays are tiny and must start from known defaults, so unlike a RAM they are reset.
      shadow_q     <= DEFAULTS;
      active_q     <= DEFAULTS;
      dirty_q      <= '0;
      op_q         <= OP_WRITE;
      idx_q        <= '0;
      data_q       <= '0;
      code_q       <= RSP_OK;
      rsp_valid_q  <= 1'b0;
      rsp_code_q   <= RSP_OK;
      cfg_update_q <= '0;
      rd_data_q    <= '0;
    end else begin
      rsp_valid_q  <= 1'b0;
      cfg_update_q <= '0;
      rd_data_q    <= rd_next;
      if (accept) begin
        op_q   <= cfg_op_e'(cmd_op);
        idx_q  <= cmd_idx;
        data_q <= cmd_data;
      end
      if (state_q == ST_CHECK) code_q <= check_code;
      if (state_q == ST_APPLY) begin
        rsp_valid_q <= 1'b1;
        rsp_code_q  <= code_q;
        if (code_q == RSP_OK) begin
          unique case (op_q)
            OP_WRITE: begin
              shadow_q[int'(wr_slot)*DW +: DW] <= data_q;
              dirty_q[wr_slot]                 <= 1'b1;
            end
            OP_COMMIT: begin
              for (int i = 0; i < NUM_CFG; i++) begin
                if (dirty_q[i]) begin
                  active_q[i*DW +: DW] <= shadow_q[i*DW +: DW];
                  cfg_update_q[i]      <= (shadow_q[i*DW +: DW] != active_q[i*DW +: DW]);
                end
              end
              dirty_q <= '0;
            end
            OP_ABORT: begin
              shadow_q <= active_q;
              dirty_q  <= '0;
            end
            OP_RESTORE: begin
              for (int i = 0; i < NUM_CFG; i++) begin
                cfg_update_q[i] <= (active_q[i*DW +: DW] != DEFAULTS[i*DW +: DW]);
              end
              active_q <= DEFAULTS;
              shadow_q <= DEFAULTS;
              dirty_q  <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_code   = rsp_code_q;
  assign rd_data    = rd_data_q;
  assign cfg_flat   = active_q;
  assign cfg_update = cfg_update_q;
  assign pending    = |dirty_q;

endmodule

// File: tb/tb_config_bank.sv
// Scoreboard bench for config_bank (IDX_W=3 build so index 4 is expressible).
module tb_config_bank;
  import cfg_pkg::*;

  localparam int NUM_CFG = 4;
  localparam int DW      = 8;
  localparam int IDX_W   = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [1:0]            cmd_op = 2'd0;
  logic [IDX_W-1:0]      cmd_idx = '0;
  logic [DW-1:0]         cmd_data = '0;
  logic                  rsp_valid;
  logic [2:0]            rsp_code;
  logic                  rd_shadow = 1'b0;
  logic [IDX_W-1:0]      rd_idx = '0;
  logic [DW-1:0]         rd_data;
  logic [NUM_CFG*DW-1:0] cfg_flat;
  logic [NUM_CFG-1:0]    cfg_update;
  logic                  pending;

  config_bank #(.IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_idx    (cmd_idx),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_code   (rsp_code),
    .rd_shadow  (rd_shadow),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .cfg_flat   (cfg_flat),
    .cfg_update (cfg_update),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of the bank contents.
  localparam int         LO[4]   = '{1, -128, -128, 1};
  localparam int         HI[4]   = '{10, 127, 127, 99};
  localparam bit         SGN[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [7:0] DFLT[4] = '{8'd2, 8'd0, 8'd9, 8'd10};

  logic [7:0] m_active[4];
  logic [7:0] m_shadow[4];
  logic [3:0] m_dirty;

  function automatic int val(input int s, input logic [7:0] d);
    return SGN[s] ? int'($signed(d)) : int'(d);
  endfunction

  function automatic logic [31:0] model_flat();
    return {m_active[3], m_active[2], m_active[1], m_active[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_active[i] = DFLT[i];
      m_shadow[i] = DFLT[i];
    end
    m_dirty = 4'b0;
  endtask

  task automatic model_cmd(input logic [1:0] op, input int idx, input logic [7:0] d,
                           output logic [2:0] code, output logic [3:0] upd);
    code = 3'd0;
    upd  = 4'b0;
    case (op)
      2'd0: begin
        if (idx >= 4) code = 3'd1;
        else if (val(idx, d) < LO[idx] || val(idx, d) > HI[idx]) code = 3'd2;
        else begin
          m_shadow[idx] = d;
          m_dirty[idx]  = 1'b1;
        end
      end
      2'd1: begin
        if (m_dirty == 4'b0) code = 3'd3;
        else if (val(1, m_shadow[1]) > val(2, m_shadow[2])) code = 3'd4;
        else begin
          for (int i = 0; i < 4; i++) begin
            if (m_dirty[i]) begin
              upd[i]      = (m_shadow[i] != m_active[i]);
              m_active[i] = m_shadow[i];
            end
          end
          m_dirty = 4'b0;
        end
      end
      2'd2: begin
        for (int i = 0; i < 4; i++) m_shadow[i] = m_active[i];
        m_dirty = 4'b0;
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          upd[i]      = (m_active[i] != DFLT[i]);
          m_active[i] = DFLT[i];
          m_shadow[i] = DFLT[i];
        end
        m_dirty = 4'b0;
      end
    endcase
  endtask

  typedef struct {
    logic [2:0] code;
    logic [3:0] upd;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rd_at_rsp = '0;
  logic [2:0] last_code = '0;

  // Response monitor: every pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rd_at_rsp = rd_data;
      last_code = rsp_code;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_code", rsp_code, e.code);
        check("cfg_update", cfg_update, e.upd);
        check("rsp_latency", cyc - e.acc, 2);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 12) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("rsp_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [1:0] op, input int idx, input logic [7:0] d);
    logic [2:0] code;
    logic [3:0] upd;
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = IDX_W'(idx);
    cmd_data  = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    model_cmd(op, idx, d, code, upd);
    sb.push_back('{code, upd, cyc + 1});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    drain();
    @(negedge clk);
    #1;
    check("pulse_end", {rsp_valid, cfg_update}, 0);
    check("cfg_flat", cfg_flat, model_flat());
    check("pending", pending, |m_dirty);
  endtask

  task automatic rd_chk(input string tag, input logic sh, input int idx, input logic [7:0] exp);
    @(negedge clk);
    rd_shadow = sh;
    rd_idx    = IDX_W'(idx);
    @(negedge clk);
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    int last;
    logic [2:0] code;
    logic [3:0] upd;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rd_data", rd_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cfg_update", cfg_update, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cfg_flat", cfg_flat, 32'h0A09_0002);
    check("rst_pending", pending, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    // Signed/unsigned writes and a clean commit; rd port watches active slot 1.
    rd_shadow = 1'b0;
    rd_idx    = 3'd1;
    issue(2'd0, 1, 8'hFB);
    issue(2'd0, 2, 8'd20);
    issue(2'd1, 0, 8'd0);
    check("commit_code", last_code, RSP_OK);
    check("apply_read_old", rd_at_rsp, 8'd0);
    check("read_after_apply", rd_data, 8'hFB);
    check("slot1_active", cfg_flat[15:8], 8'hFB);
    check("slot2_active", cfg_flat[23:16], 8'd20);

    // Range and index rejects, boundary accepts.
    issue(2'd0, 0, 8'd11);
    check("range_code", last_code, RSP_RANGE);
    rd_chk("shadow0_kept", 1'b1, 0, 8'd2);
    issue(2'd0, 3, 8'd0);
    check("range_lo_code", last_code, RSP_RANGE);
    issue(2'd0, 4, 8'd5);
    check("bad_idx_code", last_code, RSP_BAD_IDX);
    issue(2'd0, 0, 8'd10);
    issue(2'd0, 1, 8'h80);
    issue(2'd0, 2, 8'h80);
    issue(2'd0, 3, 8'd100);
    issue(2'd0, 1, 8'h7F);
    issue(2'd2, 0, 8'd0);

    // Order failure keeps the shadow; abort drops it.
    issue(2'd0, 1, 8'd7);
    issue(2'd0, 2, 8'd3);
    issue(2'd1, 0, 8'd0);
    check("order_code", last_code, RSP_ORDER);
    check("order_pending", pending, 1);
    issue(2'd2, 0, 8'd0);
    check("abort_pending", pending, 0);
    rd_chk("abort_shadow1", 1'b1, 1, 8'hFB);

    // Empty commit, then a same-value commit with no update.
    issue(2'd1, 0, 8'd0);
    check("empty_code", last_code, RSP_EMPTY);
    issue(2'd0, 3, 8'd10);
    issue(2'd1, 0, 8'd0);
    check("same_val_code", last_code, RSP_OK);

    // Restore defaults.
    issue(2'd3, 0, 8'd0);
    check("restore_flat", cfg_flat, 32'h0A09_0002);
    rd_chk("rd_oob", 1'b0, 5, 8'd0);

    // Reset while a write sits in CHECK: no response, shadow back to defaults.
    issue(2'd0, 1, 8'd40);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_idx   = 3'd0;
    cmd_data  = 8'd5;
    check("pre_rst_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", rsp_valid, 0);
    end
    check("rst_mid_flat", cfg_flat, 32'h0A09_0002);
    check("rst_mid_pending", pending, 0);
    rd_chk("rst_mid_shadow0", 1'b1, 0, 8'd2);
    rd_chk("rst_mid_shadow1", 1'b1, 1, 8'd0);

    // Back-to-back commands with cmd_valid held high.
    acc_cnt = 0;
    last    = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      if (cmd_ready) begin
        model_cmd(2'd2, 0, 8'd0, code, upd);
        sb.push_back('{code, upd, cyc + 1});
        if (last >= 0) check("b2b_spacing", cyc - last, 3);
        last = cyc;
        acc_cnt++;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_accepts", acc_cnt, 3);
    drain();

    // Random traffic against the model.
    for (int k = 0; k < 30; k++) begin
      int r;
      r = int'($urandom_range(0, 7));
      issue((r < 5) ? 2'd0 : 2'(r - 4), int'($urandom_range(0, 5)), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
